fl_header_insert: RTL and testbench

//  FrameLink block that inserts HDR_WORDS header words in front of every frame,

---
 rtl/fl_header_insert_if.sv | 21 ++
 rtl/fl_header_insert.sv | 116 +++++++++++
 tb/tb_fl_header_insert.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fl_header_insert_if.sv
// FrameLink word bus: data, byte remainder, active-low framing and handshake.
// The source drives through the master modport and the sink through the slave modport.
interface fl_header_insert_if #(
   parameter int DATA_WIDTH = 64
);
   localparam int DREM_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;

   logic [DATA_WIDTH-1:0] data;
   logic [DREM_WIDTH-1:0] rem;
   logic                  sof_n;
   logic                  eof_n;
   logic                  sop_n;
   logic                  eop_n;
   logic                  src_rdy_n;
   logic                  dst_rdy_n;

   modport master (output data, rem, sof_n, eof_n, sop_n, eop_n, src_rdy_n,
                   input  dst_rdy_n);
   modport slave  (input  data, rem, sof_n, eof_n, sop_n, eop_n, src_rdy_n,
                   output dst_rdy_n);
endinterface

// File: rtl/fl_header_insert.sv
// Inserts HDR_WORDS header words in front of each FrameLink frame, either as a
// separate part or merged into the first part; EN=0 passes frames untouched.
module fl_header_insert #(
   parameter int DATA_WIDTH = 64,
   parameter int HDR_WORDS  = 1,
   parameter int HDR_PART   = 1
) (
   input  logic                            CLK,
   input  logic                            RESET_N,
   input  logic [DATA_WIDTH*HDR_WORDS-1:0] DATA,
   input  logic                            EN,
   fl_header_insert_if.slave               rx,
   fl_header_insert_if.master              tx,
   output logic                            BUSY
);
   localparam int IDX_W = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HDR_WORDS - 1);

   typedef enum logic [1:0] {IDLE, HDR, PASS, BYPASS} state_t;

   state_t                          state_q;
   logic [IDX_W-1:0]                idx_q;
   logic [DATA_WIDTH*HDR_WORDS-1:0] hdr_q;
   logic                            first_q;
   logic                            busy_q;
   logic                            rx_xfer;

   assign rx_xfer = !rx.src_rdy_n && !tx.dst_rdy_n;
   assign BUSY    = busy_q;

   // hdr_q shifts down one word per header transfer, so the word on TX is always the low slice
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         idx_q   <= '0;
         hdr_q   <= '0;
         first_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!rx.src_rdy_n && !rx.sof_n) begin
                  if (EN) begin
                     hdr_q   <= DATA;
                     idx_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= HDR;
                  end else begin
                     state_q <= BYPASS;
                  end
               end
            end
            HDR: begin
               if (!tx.dst_rdy_n) begin
                  hdr_q <= hdr_q >> DATA_WIDTH;
                  if (idx_q == IDX_LAST) begin
                     idx_q   <= '0;
                     busy_q  <= 1'b0;
                     first_q <= 1'b1;
                     state_q <= PASS;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            PASS: begin
               if (rx_xfer) begin
                  first_q <= 1'b0;
                  if (!rx.eof_n) state_q <= IDLE;
               end
            end
            BYPASS: begin
               if (rx_xfer && !rx.eof_n) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      tx.data      = '0;
      tx.rem       = '0;
      tx.sof_n     = 1'b1;
      tx.eof_n     = 1'b1;
      tx.sop_n     = 1'b1;
      tx.eop_n     = 1'b1;
      tx.src_rdy_n = 1'b1;
      rx.dst_rdy_n = 1'b1;
      case (state_q)
         HDR: begin
            tx.data      = hdr_q[DATA_WIDTH-1:0];
            tx.rem       = '1;
            tx.sof_n     = (idx_q != '0);
            tx.sop_n     = (idx_q != '0);
            tx.eop_n     = !((HDR_PART != 0) && (idx_q == IDX_LAST));
            tx.src_rdy_n = 1'b0;
         end
         PASS, BYPASS: begin
            tx.data      = rx.data;
            tx.rem       = rx.rem;
            tx.sof_n     = rx.sof_n;
            tx.eof_n     = rx.eof_n;
            tx.sop_n     = rx.sop_n;
            tx.eop_n     = rx.eop_n;
            tx.src_rdy_n = rx.src_rdy_n;
            rx.dst_rdy_n = tx.dst_rdy_n;
            if (state_q == PASS) begin
               tx.sof_n = 1'b1;
               // a merged header already opened the part the first frame word belongs to
               if ((HDR_PART == 0) && first_q) tx.sop_n = 1'b1;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_fl_header_insert.sv
// Scoreboard bench for fl_header_insert: three instances with different header
// configurations, directed frames, expected TX words queued per instance.
module tb_fl_header_insert;
   localparam int DW = 64;
   localparam logic [3:0] F_SOF = 4'b1000, F_EOF = 4'b0100, F_SOP = 4'b0010, F_EOP = 4'b0001;
   localparam logic [3:0] F_ALL = 4'b1111;

   // f holds the framing flags active high: {sof, eof, sop, eop}
   typedef struct packed {
      logic [DW-1:0] d;
      logic [2:0]    rem;
      logic [3:0]    f;
   } wd_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [191:0]  hdr_data [3];
   logic          en       [3];
   logic [DW-1:0] rx_data  [3];
   logic [DW-1:0] tx_data  [3];
   logic [2:0]    rx_rem   [3];
   logic [2:0]    tx_rem   [3];
   logic [3:0]    rx_f     [3];
   logic [3:0]    tx_f     [3];
   logic          rx_src_n [3];
   logic          rx_dst_n [3];
   logic          tx_src_n [3];
   logic          tx_dst_n [3];
   logic          busy     [3];
   logic          rand_en  [3];
   logic          stall_q  [3] = '{1'b0, 1'b0, 1'b0};
   wd_t           held     [3];
   wd_t           exp_q    [3][$];
   int            nvec = 0;
   int            nerr = 0;

   fl_header_insert_if #(.DATA_WIDTH(DW)) rxi [3] ();
   fl_header_insert_if #(.DATA_WIDTH(DW)) txi [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_w
      assign rxi[g].data      = rx_data[g];
      assign rxi[g].rem       = rx_rem[g];
      assign rxi[g].sof_n     = ~rx_f[g][3];
      assign rxi[g].eof_n     = ~rx_f[g][2];
      assign rxi[g].sop_n     = ~rx_f[g][1];
      assign rxi[g].eop_n     = ~rx_f[g][0];
      assign rxi[g].src_rdy_n = rx_src_n[g];
      assign rx_dst_n[g]      = rxi[g].dst_rdy_n;
      assign tx_data[g]       = txi[g].data;
      assign tx_rem[g]        = txi[g].rem;
      assign tx_f[g]          = ~{txi[g].sof_n, txi[g].eof_n, txi[g].sop_n, txi[g].eop_n};
      assign tx_src_n[g]      = txi[g].src_rdy_n;
      assign txi[g].dst_rdy_n = tx_dst_n[g];
   end

   fl_header_insert #(.DATA_WIDTH(DW), .HDR_WORDS(1), .HDR_PART(1)) u_a (
      .CLK(clk), .RESET_N(rst_n), .DATA(hdr_data[0][63:0]), .EN(en[0]),
      .rx(rxi[0]), .tx(txi[0]), .BUSY(busy[0]));
   fl_header_insert #(.DATA_WIDTH(DW), .HDR_WORDS(2), .HDR_PART(0)) u_b (
      .CLK(clk), .RESET_N(rst_n), .DATA(hdr_data[1][127:0]), .EN(en[1]),
      .rx(rxi[1]), .tx(txi[1]), .BUSY(busy[1]));
   fl_header_insert #(.DATA_WIDTH(DW), .HDR_WORDS(3), .HDR_PART(1)) u_c (
      .CLK(clk), .RESET_N(rst_n), .DATA(hdr_data[2]), .EN(en[2]),
      .rx(rxi[2]), .tx(txi[2]), .BUSY(busy[2]));

   always @(negedge clk)
      for (int u = 0; u < 3; u++)
         tx_dst_n[u] = rand_en[u] ? 1'($urandom_range(0, 1)) : 1'b0;

   // Monitor: inputs only move on the falling edge, so +3 sees what the next rising edge will see
   always @(negedge clk) begin
      wd_t cur;
      wd_t e;
      #3;
      for (int u = 0; u < 3; u++) begin
         cur.d = tx_data[u]; cur.rem = tx_rem[u]; cur.f = tx_f[u];
         if (stall_q[u]) begin
            nvec++;
            if (tx_src_n[u] !== 1'b0 || cur !== held[u]) begin
               nerr++;
               $display("FAIL hold_u%0d: got %h src_n=%b, want %h src_n=0", u, cur, tx_src_n[u], held[u]);
            end
         end
         stall_q[u] = !tx_src_n[u] && tx_dst_n[u];
         held[u]    = cur;
         if (tx_src_n[u] === 1'b0 && tx_dst_n[u] === 1'b0) begin
            nvec++;
            if (exp_q[u].size() == 0) begin
               nerr++;
               $display("FAIL tx_u%0d: got unexpected word %h, want none", u, cur);
            end else begin
               e = exp_q[u].pop_front();
               if (cur !== e) begin
                  nerr++;
                  $display("FAIL tx_u%0d: got d=%h rem=%0d f=%b, want d=%h rem=%0d f=%b",
                           u, cur.d, cur.rem, cur.f, e.d, e.rem, e.f);
               end
            end
         end
      end
   end

   task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, want %h", n, act, exp);
      end
   endtask

   task automatic exp_w(input int u, input logic [DW-1:0] d, input logic [2:0] rem, input logic [3:0] f);
      wd_t e;
      e.d = d; e.rem = rem; e.f = f;
      exp_q[u].push_back(e);
   endtask

   // Called at a falling edge; returns at the falling edge after the word is taken
   task automatic send_w(input int u, input logic [DW-1:0] d, input logic [2:0] rem, input logic [3:0] f);
      bit done = 1'b0;
      rx_data[u] = d; rx_rem[u] = rem; rx_f[u] = f; rx_src_n[u] = 1'b0;
      for (int t = 0; t < 300 && !done; t++) begin
         #3 done = (rx_dst_n[u] === 1'b0);
         @(negedge clk);
      end
      if (!done) begin
         nvec++; nerr++;
         $display("FAIL rx_accept_u%0d: word %h still pending, want taken within 300 cycles", u, d);
      end
      rx_src_n[u] = 1'b1;
   endtask

   initial begin
      for (int u = 0; u < 3; u++) begin
         en[u] = 1'b0; hdr_data[u] = '0; rx_data[u] = '0; rx_rem[u] = '0;
         rx_f[u] = '0; rx_src_n[u] = 1'b1; rand_en[u] = 1'b0;
      end
      repeat (2) @(negedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
         chk($sformatf("rst_tx_src_n_u%0d", u), 64'(tx_src_n[u]), 64'd1);
         chk($sformatf("rst_rx_dst_n_u%0d", u), 64'(rx_dst_n[u]), 64'd1);
         chk($sformatf("rst_tx_data_u%0d", u), tx_data[u], 64'd0);
         chk($sformatf("rst_tx_flags_u%0d", u), 64'({tx_f[u], tx_rem[u]}), 64'd0);
         chk($sformatf("rst_busy_u%0d", u), 64'(busy[u]), 64'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // 1-word separate-part header on a 3-word frame
      en[0] = 1'b1; hdr_data[0] = 192'hA5;
      exp_w(0, 64'hA5, 3'd7, F_SOF | F_SOP | F_EOP);
      exp_w(0, 64'h1000, 3'd7, F_SOP);
      exp_w(0, 64'h1001, 3'd7, 4'b0000);
      exp_w(0, 64'h1002, 3'd6, F_EOP | F_EOF);
      send_w(0, 64'h1000, 3'd7, F_SOF | F_SOP);
      send_w(0, 64'h1001, 3'd7, 4'b0000);
      send_w(0, 64'h1002, 3'd6, F_EOP | F_EOF);

      // EN=0: 2-part frame passes untouched; then EN=1 on a one-word frame
      en[0] = 1'b0; hdr_data[0] = 192'hBAD;
      exp_w(0, 64'h2000, 3'd7, F_SOF | F_SOP);
      exp_w(0, 64'h2001, 3'd4, F_EOP);
      exp_w(0, 64'h2002, 3'd7, F_SOP);
      exp_w(0, 64'h2003, 3'd1, F_EOP | F_EOF);
      send_w(0, 64'h2000, 3'd7, F_SOF | F_SOP);
      send_w(0, 64'h2001, 3'd4, F_EOP);
      send_w(0, 64'h2002, 3'd7, F_SOP);
      send_w(0, 64'h2003, 3'd1, F_EOP | F_EOF);
      en[0] = 1'b1; hdr_data[0] = 192'h5A;
      exp_w(0, 64'h5A, 3'd7, F_SOF | F_SOP | F_EOP);
      exp_w(0, 64'h3000, 3'd3, F_SOP | F_EOP | F_EOF);
      send_w(0, 64'h3000, 3'd3, F_ALL);

      // DATA/EN changed right after SOF is sampled: header keeps the latched 0x77
      hdr_data[0] = 192'h77;
      exp_w(0, 64'h77, 3'd7, F_SOF | F_SOP | F_EOP);
      exp_w(0, 64'h4000, 3'd7, F_SOP);
      exp_w(0, 64'h4001, 3'd7, F_EOP | F_EOF);
      fork
         begin
            send_w(0, 64'h4000, 3'd7, F_SOF | F_SOP);
            send_w(0, 64'h4001, 3'd7, F_EOP | F_EOF);
         end
         begin
            @(posedge clk);
            #1 hdr_data[0] = 192'hEE; en[0] = 1'b0;
         end
      join

      // 2-word header merged into the first part
      en[1] = 1'b1; hdr_data[1] = {64'h0, 64'h22, 64'h11};
      exp_w(1, 64'h11, 3'd7, F_SOF | F_SOP);
      exp_w(1, 64'h22, 3'd7, 4'b0000);
      exp_w(1, 64'h5000, 3'd7, 4'b0000);
      exp_w(1, 64'h5001, 3'd5, F_EOP | F_EOF);
      send_w(1, 64'h5000, 3'd7, F_SOF | F_SOP);
      send_w(1, 64'h5001, 3'd5, F_EOP | F_EOF);

      // one-word frames, 3-word header, random TX backpressure, back to back
      rand_en[2] = 1'b1; en[2] = 1'b1;
      hdr_data[2] = {64'h33, 64'h22, 64'h11};
      exp_w(2, 64'h11, 3'd7, F_SOF | F_SOP);
      exp_w(2, 64'h22, 3'd7, 4'b0000);
      exp_w(2, 64'h33, 3'd7, F_EOP);
      exp_w(2, 64'h6000, 3'd2, F_SOP | F_EOP | F_EOF);
      send_w(2, 64'h6000, 3'd2, F_ALL);
      hdr_data[2] = {64'h66, 64'h55, 64'h44};
      exp_w(2, 64'h44, 3'd7, F_SOF | F_SOP);
      exp_w(2, 64'h55, 3'd7, 4'b0000);
      exp_w(2, 64'h66, 3'd7, F_EOP);
      exp_w(2, 64'h6001, 3'd7, F_SOP | F_EOP | F_EOF);
      send_w(2, 64'h6001, 3'd7, F_ALL);
      rand_en[2] = 1'b0;
      repeat (3) @(negedge clk);

      // reset in HDR after the first header word went out
      hdr_data[2] = {64'hC3, 64'hC2, 64'hC1};
      exp_w(2, 64'hC1, 3'd7, F_SOF | F_SOP);
      rx_data[2] = 64'h7000; rx_rem[2] = 3'd7; rx_f[2] = F_ALL; rx_src_n[2] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("busy_in_hdr", 64'(busy[2]), 64'd1);
      chk("rx_held_in_hdr", 64'(rx_dst_n[2]), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_tx_src_n", 64'(tx_src_n[2]), 64'd1);
      chk("async_rst_tx_data", tx_data[2], 64'd0);
      chk("async_rst_busy", 64'(busy[2]), 64'd0);
      chk("async_rst_flags", 64'(tx_f[2]), 64'd0);
      rx_src_n[2] = 1'b1;
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      hdr_data[2] = {64'hF3, 64'hF2, 64'hF1};
      exp_w(2, 64'hF1, 3'd7, F_SOF | F_SOP);
      exp_w(2, 64'hF2, 3'd7, 4'b0000);
      exp_w(2, 64'hF3, 3'd7, F_EOP);
      exp_w(2, 64'h7000, 3'd7, F_SOP | F_EOP | F_EOF);
      send_w(2, 64'h7000, 3'd7, F_ALL);

      for (int t = 0; t < 500; t++) begin
         if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
         @(negedge clk);
      end
      for (int u = 0; u < 3; u++)
         chk($sformatf("drain_u%0d", u), 64'(exp_q[u].size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish before 500us");
      $fatal(1);
   end
endmodule
